// File: rtl/seq_match_reporter.sv
// seq_match_reporter: counts "1101" detector hits per window and
// reports each window count over a valid/ready channel.
module seq_match_reporter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  input  logic             hit,
  input  logic             clr_drop,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_sat,
  output logic             rpt_drop,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] acc;
  logic             acc_sat;
  logic [WIN_W-1:0] timer;

  logic [WIN_W-1:0] reload;
  logic             at_max;
  logic [CNT_W-1:0] fin_cnt;
  logic             fin_sat;
  logic             close;
  logic             load_rpt;
  logic             drop_ev;
  logic             xfer;

  assign reload   = (win_len == '0) ? '0 : win_len - 1'b1;
  assign at_max   = (acc == MAX);
  assign fin_cnt  = (hit && !at_max) ? acc + 1'b1 : acc;
  assign fin_sat  = acc_sat | (hit & at_max);
  assign close    = (state == RUN) && en && (timer == '0);
  assign xfer     = rpt_valid & rpt_ready;
  assign load_rpt = close && (!rpt_valid || rpt_ready);
  assign drop_ev  = close && rpt_valid && !rpt_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      acc       <= '0;
      acc_sat   <= 1'b0;
      timer     <= '0;
      rpt_valid <= 1'b0;
      rpt_count <= '0;
      rpt_sat   <= 1'b0;
      rpt_drop  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          timer   <= reload;
          acc     <= '0;
          acc_sat <= 1'b0;
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
            acc   <= fin_cnt;
            if (hit && at_max)
              acc_sat <= 1'b1;
          end else begin
            timer   <= reload;
            acc     <= '0;
            acc_sat <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // a close that finds the slot busy keeps the old report
      if (load_rpt) begin
        rpt_valid <= 1'b1;
        rpt_count <= fin_cnt;
        rpt_sat   <= fin_sat;
      end else if (xfer) begin
        rpt_valid <= 1'b0;
      end

      if (drop_ev)
        rpt_drop <= 1'b1;
      else if (clr_drop)
        rpt_drop <= 1'b0;
    end
  end

endmodule
